// File: rtl/uart_receiver_if.sv
// Serial-line and byte-handshake signals of the 8N1 UART receiver.
// master is the receiver side, slave the line driver / byte consumer side.
`timescale 1ns/1ps
interface uart_receiver_if;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  uart_rx,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output uart_rx,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, valid/ready holding register.
// With edge 0 = first clock edge sampling uart_rx=0, rx_valid is registered on edge 2+HALF_BIT+9*CLKS_PER_BIT (2472) and is first seen high by edge 2473.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int CLKS_PER_BIT = 260,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic            clk_30mhz,
    input  logic            reset,
    uart_receiver_if.master rx_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         idx_q;
    logic [7:0]         shift_q;
    logic [7:0]         data_q;
    logic               valid_q;
    logic               ferr_q;
    logic               ovr_q;
    logic               busy_q;
    logic               sync1_q;
    logic               sync2_q;
    logic               rx_s;

    // Idle-high reset values keep a reset from looking like a start bit.
    always_ff @(posedge clk_30mhz) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_if.uart_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk_30mhz) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                        cnt_q <= '0;
                        idx_q <= 3'd0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // A load in the same cycle as an accept replaces the byte without a gap.
                            if (!valid_q || rx_if.rx_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.overrun   = ovr_q;
    assign rx_if.busy      = busy_q;

endmodule
